// File: rtl/sc_spi_seq_pkg.sv
// rtl/sc_spi_seq_pkg.sv - shared state encoding, status codes and poll compare helper
package sc_spi_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WBSY  = 3'd2,
        S_RUN   = 3'd3,
        S_GAP   = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_TMO = 2'b01;
    localparam logic [1:0] ST_ABT = 2'b10;

    function automatic logic poll_hit(input logic [31:0] rx,
                                      input logic [31:0] mask,
                                      input logic [31:0] value);
        return (rx & mask) == (value & mask);
    endfunction

endpackage

// File: rtl/sc_spi_seq_buf.sv
// rtl/sc_spi_seq_buf.sv - 16x32 buffer: one sync write, one async read, one registered read
module sc_spi_seq_buf
    import sc_spi_seq_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_we,
    input  logic [3:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_araddr,
    output logic [31:0] o_ardata,
    input  logic [3:0]  i_rraddr,
    output logic [31:0] o_rrdata
);

    logic [31:0] r_mem [16];
    logic [31:0] r_rdata;

    // Contents are deliberately not reset; reads racing a write see the old word.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= 32'd0;
        end else begin
            r_rdata <= r_mem[i_rraddr];
        end
    end

    assign o_ardata = r_mem[i_araddr];
    assign o_rrdata = r_rdata;

endmodule

// File: rtl/sc_spi_seq.sv
// rtl/sc_spi_seq.sv - SPI transaction sequencer: command FSM, frame/gap counters, poll compare, CS extend
module sc_spi_seq
    import sc_spi_seq_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int FCW        = 8
) (
    input  logic           SPICLK,
    input  logic           SYSRST,
    input  logic           CMDVALID,
    output logic           CMDREADY,
    input  logic [FCW-1:0] CMDFRAMES,
    input  logic           CMDKEEPCS,
    input  logic           CMDPOLL,
    input  logic [3:0]     POLLIDX,
    input  logic [31:0]    POLLMASK,
    input  logic [31:0]    POLLMATCH,
    input  logic           ABORT,
    input  logic           TXWE,
    input  logic [3:0]     TXWADDR,
    input  logic [31:0]    TXWDATA,
    input  logic [3:0]     RXRADDR,
    output logic [31:0]    RXRDATA,
    output logic           BUSY,
    output logic           DONE,
    output logic [1:0]     STATUS,
    output logic [FCW-1:0] FRAMECNT,
    output logic           SPI_START,
    input  logic           SPI_BUSY,
    output logic           SPI_CSEXTEND,
    input  logic [3:0]     SPI_TXDPT,
    output logic [31:0]    SPI_TXDATA,
    input  logic [31:0]    SPI_RXDATA,
    input  logic           SPI_RXVALID,
    input  logic [3:0]     SPI_RXDPT
);

    localparam logic [7:0] GAP_LOAD = GAP_CYCLES[7:0];

    state_t         r_state, w_state_nxt;
    logic [FCW-1:0] r_frames, r_framecnt;
    logic           r_keepcs, r_poll;
    logic [3:0]     r_pollidx;
    logic [31:0]    r_mask, r_match;
    logic [1:0]     r_status, r_end_status;
    logic           r_csext, r_abort_seen, r_match_flag, r_last;
    logic [7:0]     r_gapcnt;

    logic           w_spi_start, w_abort, w_rx_hit, w_match, w_frames_hit;
    logic [FCW-1:0] w_cnt_inc;
    logic [31:0]    w_tx_rd_unused, w_rx_ard_unused;

    sc_spi_seq_buf u_txbuf (
        .i_clk    (SPICLK),
        .i_rst    (SYSRST),
        .i_we     (TXWE),
        .i_waddr  (TXWADDR),
        .i_wdata  (TXWDATA),
        .i_araddr (SPI_TXDPT),
        .o_ardata (SPI_TXDATA),
        .i_rraddr (RXRADDR),
        .o_rrdata (w_tx_rd_unused)
    );

    sc_spi_seq_buf u_rxbuf (
        .i_clk    (SPICLK),
        .i_rst    (SYSRST),
        .i_we     (SPI_RXVALID),
        .i_waddr  (SPI_RXDPT),
        .i_wdata  (SPI_RXDATA),
        .i_araddr (SPI_RXDPT),
        .o_ardata (w_rx_ard_unused),
        .i_rraddr (RXRADDR),
        .o_rrdata (RXRDATA)
    );

    assign w_abort      = r_abort_seen | ABORT;
    assign w_rx_hit     = SPI_RXVALID && (SPI_RXDPT == r_pollidx)
                          && poll_hit(SPI_RXDATA, r_mask, r_match);
    // A hit on the very cycle SPIBUSY drops still counts for this attempt.
    assign w_match      = r_match_flag | w_rx_hit;
    assign w_cnt_inc    = (r_framecnt == '1) ? r_framecnt : r_framecnt + FCW'(1);
    assign w_frames_hit = (w_cnt_inc == r_frames);

    always_ff @(posedge SPICLK) begin
        if (SYSRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_spi_start = 1'b0;
        case (r_state)
            S_IDLE:  if (CMDVALID) w_state_nxt = S_START;
            S_START: begin
                if (w_abort) begin
                    w_state_nxt = S_FIN;
                end else if (!SPI_BUSY) begin
                    w_spi_start = 1'b1;
                    w_state_nxt = S_WBSY;
                end
            end
            S_WBSY:  if (SPI_BUSY) w_state_nxt = S_RUN;
            S_RUN:   if (!SPI_BUSY) w_state_nxt = S_GAP;
            S_GAP:   if (r_gapcnt == 8'd0) w_state_nxt = (w_abort || r_last) ? S_FIN : S_START;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge SPICLK) begin
        if (SYSRST) begin
            r_frames     <= '0;
            r_framecnt   <= '0;
            r_keepcs     <= 1'b0;
            r_poll       <= 1'b0;
            r_pollidx    <= 4'd0;
            r_mask       <= 32'd0;
            r_match      <= 32'd0;
            r_status     <= ST_OK;
            r_end_status <= ST_OK;
            r_csext      <= 1'b0;
            r_abort_seen <= 1'b0;
            r_match_flag <= 1'b0;
            r_last       <= 1'b0;
            r_gapcnt     <= 8'd0;
        end else begin
            if (ABORT && r_state != S_IDLE) r_abort_seen <= 1'b1;
            if (w_rx_hit && r_state != S_IDLE) r_match_flag <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (CMDVALID) begin
                        r_frames     <= (CMDFRAMES == '0) ? FCW'(1) : CMDFRAMES;
                        r_keepcs     <= CMDKEEPCS;
                        r_poll       <= CMDPOLL;
                        r_pollidx    <= POLLIDX;
                        r_mask       <= POLLMASK;
                        r_match      <= POLLMATCH;
                        r_framecnt   <= '0;
                        r_status     <= ST_OK;
                        r_csext      <= !CMDPOLL;
                        r_abort_seen <= 1'b0;
                        r_match_flag <= 1'b0;
                        r_last       <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_abort) begin
                        r_csext  <= 1'b0;
                        r_status <= ST_ABT;
                    end else if (!SPI_BUSY) begin
                        r_match_flag <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!SPI_BUSY) begin
                        r_framecnt   <= w_cnt_inc;
                        r_last       <= r_poll ? (w_match || w_frames_hit) : w_frames_hit;
                        r_end_status <= (r_poll && !w_match) ? ST_TMO : ST_OK;
                        r_gapcnt     <= GAP_LOAD;
                        if (!r_poll && !r_keepcs && w_frames_hit) r_csext <= 1'b0;
                    end
                end
                S_GAP: begin
                    if (r_gapcnt != 8'd0) begin
                        r_gapcnt <= r_gapcnt - 8'd1;
                    end else if (w_abort) begin
                        r_csext  <= 1'b0;
                        r_status <= ST_ABT;
                    end else if (r_last) begin
                        r_status <= r_end_status;
                    end
                end
                default: ;
            endcase
        end
    end

    assign CMDREADY     = (r_state == S_IDLE);
    assign BUSY         = (r_state != S_IDLE);
    assign DONE         = (r_state == S_FIN);
    assign STATUS       = r_status;
    assign FRAMECNT     = r_framecnt;
    assign SPI_START    = w_spi_start;
    assign SPI_CSEXTEND = r_csext;

endmodule

// File: tb/tb_sc_spi_seq.sv
// tb/tb_sc_spi_seq.sv - directed self-checking bench for sc_spi_seq with a behavioural engine model
module tb_sc_spi_seq;

    localparam int GAP = 2;
    localparam int FCW = 8;

    logic           SPICLK = 1'b0;
    logic           SYSRST = 1'b1;
    logic           CMDVALID = 1'b0;
    logic           CMDREADY;
    logic [FCW-1:0] CMDFRAMES = '0;
    logic           CMDKEEPCS = 1'b0;
    logic           CMDPOLL = 1'b0;
    logic [3:0]     POLLIDX = 4'd0;
    logic [31:0]    POLLMASK = 32'd0;
    logic [31:0]    POLLMATCH = 32'd0;
    logic           ABORT = 1'b0;
    logic           TXWE = 1'b0;
    logic [3:0]     TXWADDR = 4'd0;
    logic [31:0]    TXWDATA = 32'd0;
    logic [3:0]     RXRADDR = 4'd0;
    logic [31:0]    RXRDATA;
    logic           BUSY;
    logic           DONE;
    logic [1:0]     STATUS;
    logic [FCW-1:0] FRAMECNT;
    logic           SPI_START;
    logic           SPI_BUSY = 1'b0;
    logic           SPI_CSEXTEND;
    logic [3:0]     SPI_TXDPT = 4'd0;
    logic [31:0]    SPI_TXDATA;
    logic [31:0]    SPI_RXDATA = 32'd0;
    logic           SPI_RXVALID = 1'b0;
    logic [3:0]     SPI_RXDPT = 4'd0;

    sc_spi_seq #(.GAP_CYCLES(GAP), .FCW(FCW)) dut (
        .SPICLK       (SPICLK),
        .SYSRST       (SYSRST),
        .CMDVALID     (CMDVALID),
        .CMDREADY     (CMDREADY),
        .CMDFRAMES    (CMDFRAMES),
        .CMDKEEPCS    (CMDKEEPCS),
        .CMDPOLL      (CMDPOLL),
        .POLLIDX      (POLLIDX),
        .POLLMASK     (POLLMASK),
        .POLLMATCH    (POLLMATCH),
        .ABORT        (ABORT),
        .TXWE         (TXWE),
        .TXWADDR      (TXWADDR),
        .TXWDATA      (TXWDATA),
        .RXRADDR      (RXRADDR),
        .RXRDATA      (RXRDATA),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .STATUS       (STATUS),
        .FRAMECNT     (FRAMECNT),
        .SPI_START    (SPI_START),
        .SPI_BUSY     (SPI_BUSY),
        .SPI_CSEXTEND (SPI_CSEXTEND),
        .SPI_TXDPT    (SPI_TXDPT),
        .SPI_TXDATA   (SPI_TXDATA),
        .SPI_RXDATA   (SPI_RXDATA),
        .SPI_RXVALID  (SPI_RXVALID),
        .SPI_RXDPT    (SPI_RXDPT)
    );

    always #5 SPICLK = ~SPICLK;

    int cyc = 0;
    always @(posedge SPICLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge SPICLK);
        #1;
    endtask

    task automatic write_tx(input logic [3:0] a, input logic [31:0] d);
        TXWE = 1'b1; TXWADDR = a; TXWDATA = d;
        step();
        TXWE = 1'b0;
    endtask

    task automatic issue(input logic [FCW-1:0] frames, input logic keepcs, input logic poll,
                         input logic [31:0] mask, input logic [31:0] match);
        CMDFRAMES = frames; CMDKEEPCS = keepcs; CMDPOLL = poll;
        POLLIDX = 4'd0; POLLMASK = mask; POLLMATCH = match;
        CMDVALID = 1'b1;
        step();
        CMDVALID = 1'b0;
    endtask

    task automatic wait_start(output int c, output bit ok);
        int n = 0;
        do begin
            @(negedge SPICLK);
            n++;
        end while (SPI_START !== 1'b1 && n < 60);
        ok = (SPI_START === 1'b1);
        c = cyc;
        if (!ok) check("start_timeout", 32'd0, 32'd1);
    endtask

    // Engine model: answers one SPI_START with nw words, RX word 0 = rx0 unless looping TX back.
    task automatic do_frame(input int nw, input logic [31:0] rx0, input bit loopback, input bit abort_mid,
                            output int start_cyc, output int end_cyc,
                            output logic [31:0] tx0, output logic cs_during);
        bit ok;
        logic [31:0] txw;
        tx0 = 32'd0; cs_during = 1'b0; end_cyc = 0;
        wait_start(start_cyc, ok);
        if (ok) begin
            step();
            SPI_BUSY = 1'b1;
            if (abort_mid) ABORT = 1'b1;
            step();
            for (int i = 0; i < nw; i++) begin
                SPI_TXDPT = 4'(i);
                @(negedge SPICLK);
                txw = SPI_TXDATA;
                if (i == 0) tx0 = txw;
                SPI_RXDATA  = loopback ? txw : ((i == 0) ? rx0 : 32'd0);
                SPI_RXDPT   = 4'(i);
                SPI_RXVALID = 1'b1;
                step();
                SPI_RXVALID = 1'b0;
            end
            @(negedge SPICLK);
            cs_during = SPI_CSEXTEND;
            step();
            SPI_BUSY = 1'b0;
            end_cyc = cyc;
        end
    endtask

    task automatic wait_done(output int extra);
        int n = 0;
        extra = 0;
        do begin
            @(negedge SPICLK);
            n++;
            if (SPI_START === 1'b1) extra++;
        end while (DONE !== 1'b1 && n < 100);
        if (DONE !== 1'b1) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int sc, ec, prev_end, extra;
        logic [31:0] tx0;
        logic cs;
        logic [31:0] txv [4];
        bit ok;

        txv[0] = 32'h1111_2222; txv[1] = 32'h3333_4444;
        txv[2] = 32'hDEAD_BEEF; txv[3] = 32'h0BAD_F00D;

        SYSRST = 1'b1;
        step(); step();
        SYSRST = 1'b0;
        check("rst_cmdready", CMDREADY, 1);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_start", SPI_START, 0);
        check("rst_csext", SPI_CSEXTEND, 0);
        check("rst_status", STATUS, 0);
        check("rst_framecnt", FRAMECNT, 0);
        check("rst_rxrdata", RXRDATA, 0);

        // Normal, 3 frames, CS held across frames and released after the last
        write_tx(4'd0, 32'hA5A5_A5A5);
        issue(8'd3, 1'b0, 1'b0, 32'd0, 32'd0);
        check("n_busy", BUSY, 1);
        check("n_cmdready", CMDREADY, 0);
        do_frame(1, 32'd0, 1'b0, 1'b0, sc, prev_end, tx0, cs);
        check("n_txdata", tx0, 32'hA5A5_A5A5);
        check("n_cs_f1", cs, 1);
        for (int f = 2; f <= 3; f++) begin
            do_frame(1, 32'd0, 1'b0, 1'b0, sc, ec, tx0, cs);
            check("n_gap", 32'((sc - prev_end) >= GAP), 1);
            check("n_cs_fn", cs, 1);
            prev_end = ec;
        end
        wait_done(extra);
        check("n_extra_start", extra, 0);
        check("n_status", STATUS, 2'b00);
        check("n_framecnt", FRAMECNT, 3);
        check("n_cs_done", SPI_CSEXTEND, 0);
        step();

        // KEEPCS holds CS into idle; a following KEEPCS=0 command releases it
        issue(8'd1, 1'b1, 1'b0, 32'd0, 32'd0);
        do_frame(1, 32'd0, 1'b0, 1'b0, sc, ec, tx0, cs);
        wait_done(extra);
        step(); step();
        check("k_idle", CMDREADY, 1);
        check("k_cs_held", SPI_CSEXTEND, 1);
        issue(8'd1, 1'b0, 1'b0, 32'd0, 32'd0);
        check("k_cs_accept", SPI_CSEXTEND, 1);
        do_frame(1, 32'd0, 1'b0, 1'b0, sc, ec, tx0, cs);
        wait_done(extra);
        step();
        check("k_cs_released", SPI_CSEXTEND, 0);

        // CMDFRAMES=0 runs exactly one frame
        issue(8'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        do_frame(1, 32'd0, 1'b0, 1'b0, sc, ec, tx0, cs);
        wait_done(extra);
        check("z_extra_start", extra, 0);
        check("z_framecnt", FRAMECNT, 1);
        step();

        // Poll: WIP bit reads 1,1,0 -> match on 3rd attempt
        issue(8'd10, 1'b0, 1'b1, 32'h1, 32'h0);
        do_frame(1, 32'h1, 1'b0, 1'b0, sc, ec, tx0, cs);
        check("p_cs_f1", cs, 0);
        do_frame(1, 32'h1, 1'b0, 1'b0, sc, ec, tx0, cs);
        do_frame(1, 32'h0, 1'b0, 1'b0, sc, ec, tx0, cs);
        check("p_cs_f3", cs, 0);
        wait_done(extra);
        check("p_extra_start", extra, 0);
        check("p_status", STATUS, 2'b00);
        check("p_framecnt", FRAMECNT, 3);
        step();

        // Poll timeout after 4 attempts
        issue(8'd4, 1'b0, 1'b1, 32'h1, 32'h0);
        for (int f = 0; f < 4; f++) do_frame(1, 32'h1, 1'b0, 1'b0, sc, ec, tx0, cs);
        wait_done(extra);
        check("t_extra_start", extra, 0);
        check("t_status", STATUS, 2'b01);
        check("t_framecnt", FRAMECNT, 4);
        step();

        // ABORT during frame 2 of 5
        issue(8'd5, 1'b0, 1'b0, 32'd0, 32'd0);
        do_frame(1, 32'd0, 1'b0, 1'b0, sc, ec, tx0, cs);
        do_frame(1, 32'd0, 1'b0, 1'b1, sc, ec, tx0, cs);
        wait_done(extra);
        check("a_extra_start", extra, 0);
        check("a_status", STATUS, 2'b10);
        check("a_framecnt", FRAMECNT, 2);
        check("a_cs", SPI_CSEXTEND, 0);
        step(); step();
        check("a_idle_ignored", BUSY, 0);
        check("a_status_kept", STATUS, 2'b10);
        ABORT = 1'b0;

        // Loopback of 4 words into the RX buffer
        for (int i = 0; i < 4; i++) write_tx(4'(i), txv[i]);
        issue(8'd1, 1'b0, 1'b0, 32'd0, 32'd0);
        do_frame(4, 32'd0, 1'b1, 1'b0, sc, ec, tx0, cs);
        wait_done(extra);
        step();
        for (int i = 0; i < 4; i++) begin
            RXRADDR = 4'(i);
            step();
            check("rx_word", RXRDATA, txv[i]);
        end

        // SYSRST while frame 2 is in flight
        issue(8'd3, 1'b1, 1'b0, 32'd0, 32'd0);
        do_frame(1, 32'd0, 1'b0, 1'b0, sc, ec, tx0, cs);
        wait_start(sc, ok);
        step();
        SPI_BUSY = 1'b1;
        step(); step();
        check("r_pre_framecnt", FRAMECNT, 1);
        SYSRST = 1'b1;
        step();
        SYSRST = 1'b0;
        check("r_cmdready", CMDREADY, 1);
        check("r_busy", BUSY, 0);
        check("r_done", DONE, 0);
        check("r_start", SPI_START, 0);
        check("r_csext", SPI_CSEXTEND, 0);
        check("r_status", STATUS, 0);
        check("r_framecnt", FRAMECNT, 0);
        check("r_rxrdata", RXRDATA, 0);
        SPI_BUSY = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
